// File: rtl/por_mon_pkg.sv
// Shared definitions for the POR pulse monitor: state encoding and default
// pulse-width thresholds.
package por_mon_pkg;

  // Encoding doubles as the 2-bit status readback value.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } por_state_e;

  localparam int MIN_PULSE_DEF = 4;
  localparam int MAX_PULSE_DEF = 65535;

endpackage

// File: rtl/io_sync.sv
// Multi-flop synchroniser for an asynchronous pad input. Resets to 0.
module io_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the pad level through the chain; the last flop is the safe copy.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/por_pulse_responder.sv
// Qualifies POR pulses seen on a pad by their synchronised width, keeps a
// sticky pass flag, a stuck-high flag and saturating pulse/glitch statistics.
module por_pulse_responder
  import por_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = MIN_PULSE_DEF,
  parameter int MAX_PULSE   = MAX_PULSE_DEF,
  parameter int WIDTH_W     = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               por_in,
  input  logic               enable,
  input  logic               clear,
  output logic               test_out,
  output logic               err,
  output logic [1:0]         status,
  output logic [WIDTH_W-1:0] last_width,
  output logic [CNT_W-1:0]   pulse_count,
  output logic [CNT_W-1:0]   glitch_count
);

  localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_PULSE);
  localparam logic [WIDTH_W-1:0] MAX_W = WIDTH_W'(MAX_PULSE);

  // Statistics counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Width counter stops at the stuck-high threshold.
  function automatic logic [WIDTH_W-1:0] width_sat_inc(input logic [WIDTH_W-1:0] v);
    return (v >= MAX_W) ? MAX_W : v + WIDTH_W'(1);
  endfunction

  logic por_s, por_d, rise, fall;

  io_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .resetb (resetb),
    .din    (por_in),
    .dout   (por_s)
  );

  por_state_e         state_q, state_d;
  logic               ret_done_q, ret_done_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               test_out_q, test_out_d;
  logic               err_q, err_d;
  logic [WIDTH_W-1:0] last_width_q, last_width_d;
  logic [CNT_W-1:0]   pulse_q, pulse_d;
  logic [CNT_W-1:0]   glitch_q, glitch_d;

  // One-cycle delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) por_d <= 1'b0;
    else         por_d <= por_s;
  end

  assign rise = por_s & ~por_d;
  assign fall = ~por_s & por_d;

  // State, flags and counters register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      ret_done_q   <= 1'b0;
      width_q      <= '0;
      test_out_q   <= 1'b0;
      err_q        <= 1'b0;
      last_width_q <= '0;
      pulse_q      <= '0;
      glitch_q     <= '0;
    end else begin
      state_q      <= state_d;
      ret_done_q   <= ret_done_d;
      width_q      <= width_d;
      test_out_q   <= test_out_d;
      err_q        <= err_d;
      last_width_q <= last_width_d;
      pulse_q      <= pulse_d;
      glitch_q     <= glitch_d;
    end
  end

  // Next-state and update logic; clear overrides every pulse event.
  always_comb begin
    state_d      = state_q;
    ret_done_d   = ret_done_q;
    width_d      = width_q;
    test_out_d   = test_out_q;
    err_d        = err_q;
    last_width_d = last_width_q;
    pulse_d      = pulse_q;
    glitch_d     = glitch_q;
    if (clear) begin
      state_d      = ST_IDLE;
      ret_done_d   = 1'b0;
      width_d      = '0;
      test_out_d   = 1'b0;
      err_d        = 1'b0;
      last_width_d = '0;
      pulse_d      = '0;
      glitch_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (rise && enable) begin
            state_d    = ST_HIGH;
            // Remember where a glitch should send us back to.
            ret_done_d = (state_q == ST_DONE);
            width_d    = WIDTH_W'(1);
          end
        end
        ST_HIGH: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (fall) begin
            if (width_q >= MIN_W) begin
              state_d      = ST_DONE;
              test_out_d   = 1'b1;
              last_width_d = width_q;
              pulse_d      = cnt_sat_inc(pulse_q);
            end else begin
              state_d  = ret_done_q ? ST_DONE : ST_IDLE;
              glitch_d = cnt_sat_inc(glitch_q);
            end
          end else if (por_s) begin
            if (width_q >= MAX_W) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end else begin
              width_d = width_sat_inc(width_q);
            end
          end
        end
        ST_ERROR: begin
          if (fall) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign test_out     = test_out_q;
  assign err          = err_q;
  assign status       = state_q;
  assign last_width   = last_width_q;
  assign pulse_count  = pulse_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_por_pulse_responder.sv
`timescale 1ns/1ps
module tb_por_pulse_responder;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        por_in = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        test_out, err;
  logic [1:0]  status;
  logic [15:0] last_width;
  logic [7:0]  pulse_count, glitch_count;

  logic        por_in2 = 1'b0;
  logic        clear2 = 1'b0;
  logic        test_out2, err2;
  logic [1:0]  status2;
  logic [15:0] last_width2;
  logic [1:0]  pulse_count2, glitch_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #12.5 clock = ~clock;

  por_pulse_responder #(.SYNC_STAGES(2), .MIN_PULSE(4), .MAX_PULSE(32),
                        .WIDTH_W(16), .CNT_W(8)) dut (
    .clock(clock), .resetb(resetb), .por_in(por_in), .enable(enable),
    .clear(clear), .test_out(test_out), .err(err), .status(status),
    .last_width(last_width), .pulse_count(pulse_count),
    .glitch_count(glitch_count)
  );

  por_pulse_responder #(.SYNC_STAGES(2), .MIN_PULSE(4), .MAX_PULSE(65535),
                        .WIDTH_W(16), .CNT_W(2)) dut_c2 (
    .clock(clock), .resetb(resetb), .por_in(por_in2), .enable(enable),
    .clear(clear2), .test_out(test_out2), .err(err2), .status(status2),
    .last_width(last_width2), .pulse_count(pulse_count2),
    .glitch_count(glitch_count2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int n);
    por_in = 1'b1;
    tick(n);
    por_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b0; enable = 1'b1;
    #1;
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL rst_test_out got %0d want 0", test_out); end
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL rst_status got %0d want 0", status); end
    tick(2);
    resetb = 1'b1;
    tick(100);
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL idle_test_out got %0d want 0", test_out); end
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL idle_status got %0d want 0", status); end
    n_cmp++; if (pulse_count !== 8'd0) begin n_bad++; $display("FAIL idle_pulse got %0d want 0", pulse_count); end
    n_cmp++; if (glitch_count !== 8'd0) begin n_bad++; $display("FAIL idle_glitch got %0d want 0", glitch_count); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL idle_err got %0d want 0", err); end
    n_cmp++; if (last_width !== 16'd0) begin n_bad++; $display("FAIL idle_last_width got %0d want 0", last_width); end
  endtask

  task automatic test_valid_pulse();
    pulse(8);
    tick(1); // edge k: first edge sampling 0
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL vp_early_k got %0d want 0", test_out); end
    tick(1); // edge k+1
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL vp_early_k1 got %0d want 0", test_out); end
    n_cmp++; if (status !== 2'd1) begin n_bad++; $display("FAIL vp_status_high got %0d want 1", status); end
    tick(1); // edge k+2
    n_cmp++; if (test_out !== 1'b1) begin n_bad++; $display("FAIL vp_test_out got %0d want 1", test_out); end
    n_cmp++; if (last_width !== 16'd8) begin n_bad++; $display("FAIL vp_last_width got %0d want 8", last_width); end
    n_cmp++; if (pulse_count !== 8'd1) begin n_bad++; $display("FAIL vp_pulse got %0d want 1", pulse_count); end
    n_cmp++; if (status !== 2'd2) begin n_bad++; $display("FAIL vp_status got %0d want 2", status); end
  endtask

  task automatic test_glitch();
    do_clear();
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL clr_test_out got %0d want 0", test_out); end
    n_cmp++; if (pulse_count !== 8'd0) begin n_bad++; $display("FAIL clr_pulse got %0d want 0", pulse_count); end
    pulse(2);
    tick(4);
    n_cmp++; if (glitch_count !== 8'd1) begin n_bad++; $display("FAIL gl_glitch got %0d want 1", glitch_count); end
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL gl_test_out got %0d want 0", test_out); end
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL gl_status got %0d want 0", status); end
    pulse(6);
    tick(4);
    n_cmp++; if (test_out !== 1'b1) begin n_bad++; $display("FAIL gl6_test_out got %0d want 1", test_out); end
    n_cmp++; if (pulse_count !== 8'd1) begin n_bad++; $display("FAIL gl6_pulse got %0d want 1", pulse_count); end
    n_cmp++; if (last_width !== 16'd6) begin n_bad++; $display("FAIL gl6_last_width got %0d want 6", last_width); end
    n_cmp++; if (glitch_count !== 8'd1) begin n_bad++; $display("FAIL gl6_glitch got %0d want 1", glitch_count); end
    // A glitch after a valid pulse returns to DONE and keeps the flag.
    pulse(3);
    tick(4);
    n_cmp++; if (status !== 2'd2) begin n_bad++; $display("FAIL gl_done_status got %0d want 2", status); end
    n_cmp++; if (glitch_count !== 8'd2) begin n_bad++; $display("FAIL gl_done_glitch got %0d want 2", glitch_count); end
    n_cmp++; if (last_width !== 16'd6) begin n_bad++; $display("FAIL gl_done_last_width got %0d want 6", last_width); end
  endtask

  task automatic test_stuck();
    do_clear();
    por_in = 1'b1;
    tick(20);
    n_cmp++; if (status !== 2'd1) begin n_bad++; $display("FAIL st_mid_status got %0d want 1", status); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL st_mid_err got %0d want 0", err); end
    tick(30);
    n_cmp++; if (status !== 2'd3) begin n_bad++; $display("FAIL st_status got %0d want 3", status); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL st_err got %0d want 1", err); end
    por_in = 1'b0;
    tick(4);
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL st_rel_status got %0d want 0", status); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL st_rel_err got %0d want 1", err); end
    n_cmp++; if (pulse_count !== 8'd0) begin n_bad++; $display("FAIL st_pulse got %0d want 0", pulse_count); end
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL st_test_out got %0d want 0", test_out); end
  endtask

  task automatic test_clear_on_fall();
    pulse(8);
    tick(2); // fall is now visible to the FSM
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL cf_test_out got %0d want 0", test_out); end
    n_cmp++; if (pulse_count !== 8'd0) begin n_bad++; $display("FAIL cf_pulse got %0d want 0", pulse_count); end
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL cf_status got %0d want 0", status); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL cf_err got %0d want 0", err); end
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    pulse(8);
    tick(4);
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL en_status got %0d want 0", status); end
    n_cmp++; if (pulse_count !== 8'd0) begin n_bad++; $display("FAIL en_pulse got %0d want 0", pulse_count); end
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL en_test_out got %0d want 0", test_out); end
    enable = 1'b1;
    // Enable dropped mid-pulse abandons it without counting.
    por_in = 1'b1;
    tick(6);
    enable = 1'b0;
    tick(1);
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL en_drop_status got %0d want 0", status); end
    por_in = 1'b0;
    tick(4);
    enable = 1'b1;
    n_cmp++; if (pulse_count !== 8'd0) begin n_bad++; $display("FAIL en_drop_pulse got %0d want 0", pulse_count); end
    n_cmp++; if (glitch_count !== 8'd0) begin n_bad++; $display("FAIL en_drop_glitch got %0d want 0", glitch_count); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      por_in2 = 1'b1;
      tick(6);
      por_in2 = 1'b0;
      tick(4);
      if (i == 1) begin
        n_cmp++; if (pulse_count2 !== 2'd2) begin n_bad++; $display("FAIL sat_two got %0d want 2", pulse_count2); end
      end
    end
    n_cmp++; if (pulse_count2 !== 2'd3) begin n_bad++; $display("FAIL sat_pulse got %0d want 3", pulse_count2); end
    n_cmp++; if (test_out2 !== 1'b1) begin n_bad++; $display("FAIL sat_test_out got %0d want 1", test_out2); end
    n_cmp++; if (last_width2 !== 16'd6) begin n_bad++; $display("FAIL sat_last_width got %0d want 6", last_width2); end
    n_cmp++; if (pulse_count !== 8'd0) begin n_bad++; $display("FAIL sat_isolation got %0d want 0", pulse_count); end
  endtask

  task automatic test_reset_mid();
    por_in = 1'b1;
    tick(5);
    n_cmp++; if (status !== 2'd1) begin n_bad++; $display("FAIL rm_pre_status got %0d want 1", status); end
    #3 resetb = 1'b0;
    #1;
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL rm_status got %0d want 0", status); end
    n_cmp++; if (pulse_count2 !== 2'd0) begin n_bad++; $display("FAIL rm_pulse2 got %0d want 0", pulse_count2); end
    n_cmp++; if (test_out2 !== 1'b0) begin n_bad++; $display("FAIL rm_test_out2 got %0d want 0", test_out2); end
    por_in = 1'b0;
    tick(2);
    resetb = 1'b1;
    tick(6);
    n_cmp++; if (test_out !== 1'b0) begin n_bad++; $display("FAIL rm_test_out got %0d want 0", test_out); end
    n_cmp++; if (status !== 2'd0) begin n_bad++; $display("FAIL rm_post_status got %0d want 0", status); end
    n_cmp++; if (glitch_count !== 8'd0) begin n_bad++; $display("FAIL rm_glitch got %0d want 0", glitch_count); end
  endtask

  initial begin
    test_reset();
    test_valid_pulse();
    test_glitch();
    test_stuck();
    test_clear_on_fall();
    test_enable_off();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/por_pulse_responder.md
Name: por_pulse_responder

Overview:
- User-project-side responder for the power-on-reset pulse stimulus driven onto an mprj_io pad.
- Synchronises the pad input and qualifies each pulse by width.
- Reports a sticky pass flag on test_out, plus pulse and glitch statistics for management readback.
- Sits in the user project area between the POR pad input and the GPIO output, and feeds a Wishbone-readable status register.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count on por_in (≥2).
- MIN_PULSE, 4, minimum synchronised high width in cycles to count as valid.
- MAX_PULSE, 65535, high width at which the input is declared stuck (≤ 2^WIDTH_W − 1).
- WIDTH_W, 16, width of the pulse-width counter and last_width.
- CNT_W, 8, width of the saturating pulse and glitch counters.

Ports:
- clock  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- por_in  in  1  asynchronous POR pulse from the pad
- enable  in  1  monitor enable; 0 holds the FSM in IDLE
- clear  in  1  synchronous clear of flags, counters and FSM
- test_out  out  1  sticky: at least one valid pulse seen since reset/clear
- err  out  1  sticky: stuck-high detected
- status  out  2  FSM state: 0 IDLE, 1 HIGH, 2 DONE, 3 ERROR
- last_width  out  WIDTH_W  width of the last valid pulse
- pulse_count  out  CNT_W  valid pulses, saturating
- glitch_count  out  CNT_W  sub-MIN_PULSE pulses, saturating

Behaviour:
- Reset (resetb=0, async): every flop clears. All outputs are 0, FSM is IDLE, synchroniser chain is 0.
- Synchroniser:
  - por_s is the last of SYNC_STAGES flops; por_d is por_s delayed one cycle.
  - rise = por_s & ~por_d; fall = ~por_s & por_d.
- Width counter:
  - Loads 1 on entry to HIGH.
  - Increments each cycle por_s stays 1.
  - Saturates at MAX_PULSE.
- FSM transitions:
  - IDLE: on rise & enable → HIGH.
  - HIGH, fall with width ≥ MIN_PULSE → DONE. Same edge: test_out←1, last_width←width, pulse_count+1.
  - HIGH, fall with width < MIN_PULSE → previous resting state (IDLE or DONE). Same edge: glitch_count+1; test_out and last_width unchanged.
  - HIGH, width reaches MAX_PULSE while por_s=1 → ERROR, err←1.
  - HIGH, enable drops → IDLE with no counter update; test_out unchanged.
  - DONE: on rise & enable → HIGH. test_out stays 1.
  - ERROR: on fall → IDLE. err remains set.
- Latency: let edge k be the first clock edge sampling por_in=0 after a valid pulse. test_out and pulse_count update at edge k+SYNC_STAGES.
- Width definition: a por_in high level spanning N sampled edges yields width N (±1 for metastability resolution).
- Counters: both saturate at 2^CNT_W−1 and never wrap.
- Clear:
  - Next edge: FSM→IDLE; test_out, err, last_width and both counters → 0.
  - clear has priority over any same-cycle fall/rise/error event.
  - The synchroniser is not cleared.
- enable=0: rising edges are ignored and counters are frozen. Already-set flags hold.
- Simultaneous rise and clear: clear wins, FSM stays IDLE. The pulse is not counted because its rise has been consumed.
- Reset mid-pulse: immediate return to all-zero. A subsequent fall with no preceding rise is ignored.

Decomposition:
- Package por_mon_pkg holds:
  - the state enum (IDLE, HIGH, DONE, ERROR) with the 2-bit status encoding;
  - default constants for MIN_PULSE and MAX_PULSE.
- Sub-module io_sync (parameterised SYNC_STAGES, async active-low reset to 0), reusable for other pad inputs.
- The edge detector, FSM and counters live in por_pulse_responder.

Test Plan:
- Reset, enable=1, por_in=0 for 100 cycles → test_out=0, status=0, all counters 0.
- 8-cycle por_in pulse (200 ns at 25 ns clock) → test_out=1 exactly SYNC_STAGES edges after the fall, last_width=8, pulse_count=1, status=2.
- 2-cycle pulse, then a 6-cycle pulse → after the first, glitch_count=1 and test_out=0; after the second, test_out=1, pulse_count=1, last_width=6.
- MAX_PULSE=32, por_in held high 50 cycles, then released → status=3 and err=1 once width hits 32; status=0 after the fall; err stays 1; pulse_count=0.
- clear asserted on the same cycle the FSM sees the fall of a valid pulse → test_out=0, pulse_count=0, status=0 on the next edge.
- CNT_W=2, five valid pulses → pulse_count=3.
- resetb driven low mid-HIGH → all outputs 0 with no clock edge; after release, por_in falling alone leaves test_out=0.
